// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter that shares one fixed-latency FP32 adder between N_REQ
// requesters. Each requester has one outstanding operation at most. A tag
// shift register follows every issued operation, so the adder result is
// routed back into that requester's one-entry response buffer.
module fpadd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [32*N_REQ-1:0]    req_a,
  input  logic [32*N_REQ-1:0]    req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [32*N_REQ-1:0]    rsp_data,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [31:0]            fpa_a,
  output logic [31:0]            fpa_b,
  input  logic [31:0]            fpa_result,
  output logic [CNT_W-1:0]       issue_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   busy_q, busy_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [32*N_REQ-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]   issue_count_q, issue_count_d;
  logic               tag_vld_q [ADD_LAT];
  logic [IDX_W-1:0]   tag_idx_q [ADD_LAT];

  logic [N_REQ-1:0]   eligible;
  logic               grant_any;
  logic [IDX_W-1:0]   winner;
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;
  logic               wb_vld;
  logic [IDX_W-1:0]   wb_idx;

  // Round-robin search starting at rr_ptr; reset gates every request off.
  always_comb begin
    eligible  = req_valid & ~busy_q & {N_REQ{reset}};
    grant_any = 1'b0;
    winner    = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!grant_any && eligible[cand_idx]) begin
        grant_any = 1'b1;
        winner    = cand_idx;
      end
    end
  end

  // One-hot grant and operand mux toward the adder; zeros when idle.
  always_comb begin
    req_ready = '0;
    fpa_a     = '0;
    fpa_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && (winner == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        fpa_a        = req_a[32*i +: 32];
        fpa_b        = req_b[32*i +: 32];
      end
    end
  end

  assign wb_vld = tag_vld_q[ADD_LAT-1];
  assign wb_idx = tag_idx_q[ADD_LAT-1];

  // Next-state for pointer, counter, busy flags and response buffers.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    issue_count_d = issue_count_q;
    busy_d        = busy_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    if (grant_any) begin
      rr_ptr_d      = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      issue_count_d = issue_count_q + 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      // busy spans in-flight plus buffer-full, so set and clear never collide
      if (req_ready[i]) begin
        busy_d[i] = 1'b1;
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        busy_d[i] = 1'b0;
      end
      if (wb_vld && (wb_idx == IDX_W'(i))) begin
        rsp_valid_d[i]        = 1'b1;
        rsp_data_d[32*i +: 32] = fpa_result;
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  // State registers; reset drops in-flight tags so late adder outputs are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q      <= '0;
      issue_count_q <= '0;
      busy_q        <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      for (int s = 0; s < ADD_LAT; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_idx_q[s] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_count_q <= issue_count_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      tag_vld_q[0]  <= grant_any;
      tag_idx_q[0]  <= winner;
      for (int s = 1; s < ADD_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter: a recorder pushes the hand-computed
// result on each handshake, a monitor pops and compares on each rising rsp_valid.
module tb_fpadd_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [32*N-1:0] rsp_data;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     fpa_a, fpa_b, fpa_result;
  logic [CW-1:0]   issue_count;

  fpadd_arbiter #(.N_REQ(N), .ADD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_result(fpa_result),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
  endtask

  // Adder stand-in: table of hand-computed FP32 sums, fixed latency LAT.
  function automatic logic [31:0] fp_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3FC00000, 32'h40200000}: return 32'h40800000;
      {32'h40000000, 32'hBF800000}: return 32'h3F800000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] add_pipe [LAT];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < LAT; s++) add_pipe[s] <= '0;
    end else begin
      add_pipe[0] <= fp_lut(fpa_a, fpa_b);
      for (int s = 1; s < LAT; s++) add_pipe[s] <= add_pipe[s-1];
    end
  end
  assign fpa_result = add_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t        sbq [N][$];
  logic [31:0] exp_val [N];
  int          hs_cnt [N];
  int          hs_total = 0;
  logic        fair_mode = 1'b0;
  int          fair_next = 0;

  // Recorder: push expected result on every handshake; grant-order checks.
  always @(negedge clk) begin
    if (!fair_mode) fair_next = 0;
    if (reset) begin
      if (req_ready != '0) check("grant_onehot", 128'($countones(req_ready)), 128'd1);
      if (fair_mode) begin
        check("rr_order", 128'(req_ready), 128'(1) << fair_next);
        fair_next = (fair_next + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.data = exp_val[i];
          e.cyc  = cyc;
          sbq[i].push_back(e);
          hs_cnt[i]++;
          hs_total++;
        end
      end
    end
  end

  // Monitor: on each new response compare data and latency against the queue.
  logic [N-1:0] prev_v = '0;
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) sbq[i].delete();
      prev_v = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && !prev_v[i]) begin
          if (sbq[i].size() == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected[%0d]: got data 'h%0h, want no response", i, rsp_data[32*i +: 32]);
          end else begin
            exp_t e;
            e = sbq[i].pop_front();
            check($sformatf("rsp_data[%0d]", i), 128'(rsp_data[32*i +: 32]), 128'(e.data));
            check($sformatf("rsp_latency[%0d]", i), 128'(cyc - e.cyc), 128'(LAT + 1));
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    exp_val[i]        = e;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    n_chk++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    int g0, g3, tot0;
    logic seen;
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin exp_val[i] = '0; hs_cnt[i] = 0; end
    #1;
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_data", 128'(rsp_data), 128'd0);
    check("rst_issue_count", 128'(issue_count), 128'd0);
    check("rst_fpa", 128'({fpa_a, fpa_b}), 128'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single op 1.0 + 2.0 with a held response buffer.
    rsp_ready[0] = 1'b0;
    set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    req_valid[0] = 1'b1;
    #1;
    check("single_grant", 128'(req_ready), 128'b0001);
    check("single_fpa_a", 128'(fpa_a), 128'h3F800000);
    tick();
    req_valid[0] = 1'b0;
    check("single_count", 128'(issue_count), 128'd1);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (rsp_valid[0]) seen = 1'b1; else tick();
    end
    check("single_rsp_seen", 128'(seen), 128'd1);
    tick(); tick();
    check("single_hold_v", 128'(rsp_valid[0]), 128'd1);
    check("single_hold_d", 128'(rsp_data[31:0]), 128'h40400000);
    rsp_ready[0] = 1'b1;
    tick();
    check("single_clear", 128'(rsp_valid[0]), 128'd0);

    // Result routing: requesters 1 and 2 in consecutive cycles.
    set_op(1, 32'h3FC00000, 32'h40200000, 32'h40800000);
    set_op(2, 32'h40000000, 32'hBF800000, 32'h3F800000);
    req_valid = 4'b0010;
    #1 check("route_grant1", 128'(req_ready), 128'b0010);
    tick();
    req_valid = 4'b0100;
    #1 check("route_grant2", 128'(req_ready), 128'b0100);
    tick();
    req_valid = '0;
    repeat (6) tick();
    check("route_data1", 128'(rsp_data[63:32]), 128'h40800000);
    check("route_data2", 128'(rsp_data[95:64]), 128'h3F800000);

    // Fairness: all requesters continuously valid, consumers ready.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'h3F800000, 32'h3F800000, 32'h40000000);
    fair_mode = 1'b1;
    req_valid = '1;
    repeat (16) tick();
    fair_mode = 1'b0;
    req_valid = '0;
    repeat (6) tick();
    check("fair_count16", 128'(issue_count), 128'd0);

    // Counter wrap: 17 issues into a 4-bit counter.
    do_reset();
    tot0 = hs_total;
    req_valid = '1;
    for (int k = 0; k < 40 && (hs_total - tot0) < 17; k++) tick();
    req_valid = '0;
    tick();
    check("wrap_count", 128'(issue_count), 128'd1);
    repeat (6) tick();

    // Backpressure on requester 3 while 0 and 1 keep issuing.
    set_op(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    set_op(3, 32'h40000000, 32'h40000000, 32'h40800000);
    rsp_ready[3] = 1'b0;
    g3 = hs_cnt[3];
    req_valid = 4'b1011;
    for (int k = 0; k < 6 && hs_cnt[3] == g3; k++) tick();
    check("bp_first_grant", 128'(hs_cnt[3] - g3), 128'd1);
    g0 = hs_cnt[0];
    for (int k = 0; k < 10; k++) begin
      #1;
      check("bp_no_regrant", 128'(req_ready[3]), 128'd0);
      if (k > 4) check("bp_hold_data", 128'(rsp_data[127:96]), 128'h40800000);
      tick();
    end
    check("bp_rsp_valid", 128'(rsp_valid[3]), 128'd1);
    check("bp_others_granted", 128'((hs_cnt[0] - g0) >= 2), 128'd1);
    req_valid = 4'b1000;
    rsp_ready[3] = 1'b1;
    tick();
    rsp_ready[3] = 1'b0;
    #1 check("bp_regrant", 128'(req_ready[3]), 128'd1);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (8) tick();

    // Reset one cycle after a grant to requester 0.
    set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001;
    #1 check("mid_grant", 128'(req_ready), 128'b0001);
    tick();
    req_valid = '0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("mid_rst_count", 128'(issue_count), 128'd0);
    check("mid_rst_ready", 128'(req_ready), 128'd0);
    check("mid_rst_fpa", 128'({fpa_a, fpa_b}), 128'd0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    check("mid_no_rsp", 128'(rsp_valid), 128'd0);
    set_op(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    set_op(2, 32'h3F800000, 32'h3F800000, 32'h40000000);
    set_op(3, 32'h3F800000, 32'h3F800000, 32'h40000000);
    req_valid = '1;
    #1 check("mid_ptr_zero", 128'(req_ready), 128'b0001);
    tick();
    req_valid = '0;
    repeat (8) tick();

    for (int i = 0; i < N; i++) check($sformatf("sb_drained[%0d]", i), 128'(sbq[i].size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
- Shares one pipelined FP32 adder (fixed latency ADD_LAT, no valid/ready of its own) between N_REQ requesters.
- Requester side: per-requester valid/ready request channel and a one-entry response buffer.
- Grant policy: round-robin.
- Tracking: a tag shift register follows each in-flight operation so the result returns to the requester that issued it.
- Sits between the compute clients and the fpadd_pipe datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADD_LAT, 2, cycles from operands on fpa_a/fpa_b (sampled at the end of cycle t) to a valid fpa_result (during cycle t+ADD_LAT).
- CNT_W, 16, width of the issue counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_a  in  32*N_REQ  operand A, requester i at bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same packing.
- req_ready  out  N_REQ  grant; handshake when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  N_REQ  result buffer i full.
- rsp_data  out  32*N_REQ  result buffer contents, same packing.
- rsp_ready  in  N_REQ  consumer accepts rsp_data[i].
- fpa_a  out  32  operand A to the adder.
- fpa_b  out  32  operand B to the adder.
- fpa_result  in  32  adder result.
- issue_count  out  CNT_W  total accepted operations, wraps at 2^CNT_W.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset).
- The adder's active-high reset is driven by ~reset at integration.

Reset (reset low):
- rr_ptr = 0.
- busy = 0, rsp_valid = 0, rsp_data = 0.
- Tag pipeline: all entries invalid.
- issue_count = 0.
- req_ready = 0 (combinational; it is 0 because busy logic and the reset gate force it so).
- fpa_a = fpa_b = 0.

State:
- busy[i] is set on a handshake for requester i.
- busy[i] is cleared when rsp_valid[i] and rsp_ready[i] are both high.
- busy[i] covers both the in-flight interval and the full-buffer interval, so each requester has at most one operation outstanding. Buffer overflow is therefore impossible.

Arbitration (combinational, every cycle):
- eligible[i] = req_valid[i] & ~busy[i] & reset.
- The winner is the first eligible index searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
- req_ready is one-hot on the winner, or zero if no index is eligible.
- req_ready never depends on rsp_ready in the same cycle (no bypass). A slot freed in cycle t is grantable from t+1.

Issue:
- In the grant cycle t: fpa_a/fpa_b = req_a/req_b of the winner.
- With no grant, fpa_a/fpa_b = 0.
- At the end of cycle t: rr_ptr <= (winner+1) mod N_REQ, and issue_count increments.
- With no grant, rr_ptr holds.
- At most one issue per cycle; back-to-back issues from different requesters are allowed.

Tag pipeline:
- ADD_LAT stages of {valid, index}.
- Stage 0 loads {grant_any, winner} at the end of cycle t.
- The last stage is valid during cycle t+ADD_LAT.
- When the last stage is valid, fpa_result is written into rsp_data[index] and rsp_valid[index] is set at the end of that cycle.

Latency and throughput:
- Handshake in cycle t gives rsp_valid high from cycle t+ADD_LAT+1.
- rsp_valid stays high, with rsp_data stable, until rsp_ready is sampled high.
- Per-requester throughput is at most 1/(ADD_LAT+2) with an always-ready consumer.
- Aggregate throughput is 1 op/cycle with at least ADD_LAT+2 active requesters.

Boundary conditions:
- Simultaneous response consume and result write for different requesters are independent.
- The same-requester case cannot occur, because busy blocks reissue before the consume.
- If rr_ptr points at a non-eligible index, the search skips it. rr_ptr advances only on a grant.
- Reset asserted mid-operation: in-flight tags are dropped immediately. Adder outputs emerging after reset release are ignored because their tags are invalid. Response buffers are cleared.
- issue_count wraps from 2^CNT_W-1 to 0.
- The block does not inspect or alter FP values. Operand legality (normal numbers, no overflow) is the requester's responsibility.

Test Plan:
- Single op:
  - Stimulus: requester 0 sends A=0x3F800000 (1.0), B=0x40000000 (2.0) at cycle 5.
  - Required: req_ready[0] high in cycle 5; rsp_valid[0] rises at cycle 8 with rsp_data[0]=0x40400000; it clears the cycle after rsp_ready[0]=1; issue_count=1.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid continuously; consumers always ready.
  - Required: grants ordered 0,1,2,3,0,... with one grant per cycle; each requester is re-granted no earlier than 4 cycles after its previous grant.
- Result routing:
  - Stimulus: requester 1 sends 1.5+2.5 and requester 2 sends 0x40000000 + 0xBF800000 (2.0 + -1.0) in consecutive cycles.
  - Required: rsp_data[1]=0x40800000 and rsp_data[2]=0x3F800000, each arriving exactly ADD_LAT+1 cycles after its own grant.
- Backpressure:
  - Stimulus: requester 3 has rsp_ready[3]=0 for 10 cycles with req_valid[3] held high.
  - Required: req_ready[3]=0 throughout; rsp_data[3] stays stable; other requesters are still granted; one cycle after rsp_ready[3] is pulsed, req_ready[3] may go high.
- Reset mid-flight:
  - Stimulus: assert reset one cycle after a grant to requester 0.
  - Required: all outputs reach their reset values asynchronously; after release, no rsp_valid[0] appears from the dropped op; rr_ptr=0.
- Counter wrap:
  - Stimulus: CNT_W=4, issue 17 ops.
  - Required: issue_count=1.
